// File: rtl/mem_responder.sv
// Multi-cycle data-memory responder: accepts one word request, holds the pipeline
// with stall for LAT cycles, then pulses done with read data or an alignment error.
module mem_responder #(
  parameter int LAT    = 4,
  parameter int MEM_AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        createdump,
  output logic [15:0] data_out,
  output logic        stall,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  logic [3:0]          cnt_r;
  logic [MEM_AW-1:0]   reqIdx_r;
  logic                reqWr_r;
  logic [15:0]         reqData_r;
  logic                unalign_r;
  logic                done_r;
  logic                err_r;
  logic [15:0]         dataOut_r;
  logic [15:0]         mem_r [2**MEM_AW];

  logic                accept_s;
  logic                finish_s;
  logic                curWr_s;
  logic                curUnalign_s;
  logic [MEM_AW-1:0]   curIdx_s;
  logic [15:0]         curData_s;
  logic                memWe_s;
  logic                unusedAddrHi_s;

  // Address bits above the word index alias onto the same array entry.
  assign unusedAddrHi_s = ^addr[15:MEM_AW+1];

  // Select the request that completes this edge; with LAT=1 it is the one being accepted.
  always_comb begin
    accept_s = enable && ((state_r == IDLE) || (state_r == DONE));
    if (LAT == 1) begin
      finish_s     = accept_s;
      curWr_s      = wr;
      curUnalign_s = addr[0];
      curIdx_s     = addr[MEM_AW:1];
      curData_s    = data_in;
    end else begin
      finish_s     = (state_r == BUSY) && (cnt_r == 4'd1);
      curWr_s      = reqWr_r;
      curUnalign_s = unalign_r;
      curIdx_s     = reqIdx_r;
      curData_s    = reqData_r;
    end
    memWe_s = finish_s && curWr_s && !curUnalign_s;
  end

  assign stall    = (state_r == BUSY) || (enable && (state_r == IDLE));
  assign done     = done_r;
  assign err      = err_r;
  assign data_out = dataOut_r;

  // Control FSM, request latch and registered completion outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      reqIdx_r  <= '0;
      reqWr_r   <= 1'b0;
      reqData_r <= 16'h0000;
      unalign_r <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      dataOut_r <= 16'h0000;
    end else begin
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      dataOut_r <= 16'h0000;
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            reqIdx_r  <= addr[MEM_AW:1];
            reqWr_r   <= wr;
            reqData_r <= data_in;
            unalign_r <= addr[0];
            if (LAT == 1) begin
              state_r <= DONE;
              cnt_r   <= 4'd0;
            end else begin
              state_r <= BUSY;
              cnt_r   <= 4'(LAT - 1);
            end
          end else begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
          end
        end
        BUSY: begin
          cnt_r <= cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            state_r <= DONE;
          end else begin
            state_r <= BUSY;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
      // Completion results are produced on the DONE entry edge, whichever path leads there.
      if (finish_s) begin
        done_r    <= 1'b1;
        err_r     <= curUnalign_s;
        dataOut_r <= (!curWr_s && !curUnalign_s) ? mem_r[curIdx_s] : 16'h0000;
      end
    end
  end

  // Array storage; contents survive rst, and a reset edge never commits a write.
  always_ff @(posedge clk) begin
    if (memWe_s && !rst) begin
      mem_r[curIdx_s] <= curData_s;
    end
  end

`ifndef SYNTHESIS
  task automatic dumpMem();
    for (int i = 0; i < 2**MEM_AW; i++) begin
      $display("%h %h", 16'(i * 2), mem_r[i]);
    end
  endtask

  // Simulation-only array dump, independent of FSM state.
  always_ff @(posedge clk) begin
    if (createdump) begin
      dumpMem();
    end
  end
`else
  logic unusedDump_s;
  assign unusedDump_s = createdump;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LAT=4 instance for the main sequence and
// a LAT=1 instance for single-cycle latency and address aliasing.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en1, en2;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] din;
  logic        cd;
  logic [15:0] d1, d2;
  logic        s1, s2, dn1, dn2, e1, e2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.LAT(4), .MEM_AW(10)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .wr(wr), .addr(addr), .data_in(din),
    .createdump(cd), .data_out(d1), .stall(s1), .done(dn1), .err(e1)
  );

  mem_responder #(.LAT(1), .MEM_AW(10)) dut2 (
    .clk(clk), .rst(rst), .enable(en2), .wr(wr), .addr(addr), .data_in(din),
    .createdump(cd), .data_out(d2), .stall(s2), .done(dn2), .err(e2)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete request on DUT sel, enable held until done, then dropped.
  task automatic runReq(input int sel, input logic w, input logic [15:0] a,
                        input logic [15:0] dIn, input int lat,
                        input logic expErr, input logic [15:0] expData);
    wr = w; addr = a; din = dIn;
    if (sel == 1) en1 = 1'b1; else en2 = 1'b1;
    #1;
    for (int c = 0; c < lat; c++) begin
      check("stallHigh", 16'(sel == 1 ? s1 : s2), 16'd1);
      check("doneLow", 16'(sel == 1 ? dn1 : dn2), 16'd0);
      step();
    end
    check("donePulse", 16'(sel == 1 ? dn1 : dn2), 16'd1);
    check("stallInDone", 16'(sel == 1 ? s1 : s2), 16'd0);
    check("errFlag", 16'(sel == 1 ? e1 : e2), 16'(expErr));
    check("dataOut", sel == 1 ? d1 : d2, expData);
    en1 = 1'b0; en2 = 1'b0;
    step();
    check("doneAfter", 16'(sel == 1 ? dn1 : dn2), 16'd0);
    check("dataAfter", sel == 1 ? d1 : d2, 16'h0000);
  endtask

  initial begin
    rst = 1'b1; en1 = 1'b0; en2 = 1'b0; wr = 1'b0;
    addr = 16'h0000; din = 16'h0000; cd = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rstData", d1, 16'h0000);
    check("rstStall", 16'(s1), 16'd0);
    check("rstDone", 16'(dn1), 16'd0);
    check("rstErr", 16'(e1), 16'd0);
    rst = 1'b0;
    step();

    // 1: aligned write
    runReq(1, 1'b1, 16'h0010, 16'hBEEF, 4, 1'b0, 16'h0000);
    // 2: read back
    runReq(1, 1'b0, 16'h0010, 16'h0000, 4, 1'b0, 16'hBEEF);
    // 3: unaligned write makes no access
    runReq(1, 1'b1, 16'h0011, 16'h5555, 4, 1'b1, 16'h0000);
    runReq(1, 1'b0, 16'h0010, 16'h0000, 4, 1'b0, 16'hBEEF);

    // 4: reset during the second busy cycle drops the write
    wr = 1'b1; addr = 16'h0010; din = 16'h1234; en1 = 1'b1;
    step();
    check("rstMidBusy1", 16'(s1), 16'd1);
    step();
    check("rstMidBusy2", 16'(s1), 16'd1);
    rst = 1'b1;
    #1;
    check("rstMidDone", 16'(dn1), 16'd0);
    check("rstMidErr", 16'(e1), 16'd0);
    check("rstMidData", d1, 16'h0000);
    check("rstMidStallEn", 16'(s1), 16'd1);
    en1 = 1'b0;
    #1;
    check("rstMidStall", 16'(s1), 16'd0);
    step();
    rst = 1'b0;
    step();
    check("postRstDone", 16'(dn1), 16'd0);
    runReq(1, 1'b0, 16'h0010, 16'h0000, 4, 1'b0, 16'hBEEF);

    // 5: write then back-to-back read accepted in the DONE cycle
    wr = 1'b1; addr = 16'h0020; din = 16'hA5A5; en1 = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      check("b2bWrStall", 16'(s1), 16'd1);
      step();
    end
    check("b2bWrDone", 16'(dn1), 16'd1);
    check("b2bWrErr", 16'(e1), 16'd0);
    wr = 1'b0;
    #1;
    check("b2bStallInDone", 16'(s1), 16'd0);
    step();
    for (int c = 0; c < 3; c++) begin
      check("b2bRdStall", 16'(s1), 16'd1);
      check("b2bRdBusyDone", 16'(dn1), 16'd0);
      step();
    end
    check("b2bRdDone", 16'(dn1), 16'd1);
    check("b2bRdData", d1, 16'hA5A5);
    en1 = 1'b0;
    step();
    check("b2bAfterData", d1, 16'h0000);

    // 6: LAT=1 instance, aliasing through upper address bits
    runReq(2, 1'b1, 16'h0010, 16'hBEEF, 1, 1'b0, 16'h0000);
    runReq(2, 1'b0, 16'h0810, 16'h0000, 1, 1'b0, 16'hBEEF);
    runReq(2, 1'b0, 16'h0021, 16'h0000, 1, 1'b1, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
